// File: rtl/id_scoreboard_fwd_pkg.sv
// id_scoreboard_fwd_pkg: shared GPR constants and forward-slot layout for the ID hazard unit
package id_scoreboard_fwd_pkg;
  localparam int GPR_NUM = 32;
  localparam int GPR_AW = 5;
  typedef struct packed {
    logic [GPR_AW-1:0] dest;
    logic [31:0]       data;
    logic              data_ok;
    logic              valid;
  } fwd_slot_t;
endpackage

// File: rtl/id_scoreboard_fwd_fwd_select_port.sv
// fwd_select_port: youngest-first forward select for one source port, with port stall
module fwd_select_port
  import id_scoreboard_fwd_pkg::*;
#(
  parameter int NFWD = 3
) (
  input  logic                    hazard,
  input  logic [GPR_AW-1:0]       addr,
  input  logic [31:0]             rf_rdata,
  input  fwd_slot_t [NFWD-1:0]    slots,
  output logic [31:0]             value,
  output logic                    port_stall
);
  logic        hit;
  logic        ok;
  logic [31:0] data;
  always_comb begin
    hit = 1'b0;
    ok = 1'b0;
    data = rf_rdata;
    for (int i = NFWD - 1; i >= 0; i--)
      if (slots[i].valid && slots[i].dest == addr) begin
        hit = 1'b1;
        ok = slots[i].data_ok;
        data = slots[i].data;
      end
    value = (hazard && hit && ok) ? data : rf_rdata;
    port_stall = hazard && !(hit && ok);
  end
endmodule

// File: rtl/id_scoreboard_fwd.sv
// id_scoreboard_fwd: decode-stage hazard/forwarding unit with per-GPR in-flight writer counters
module id_scoreboard_fwd
  import id_scoreboard_fwd_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int NFWD = 3,
  parameter int MAX_INFLIGHT = 3,
  parameter int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     ex_allow_in,
  output logic                     issue_ready,
  input  logic                     issue_we,
  input  logic [GPR_AW-1:0]        issue_dest,
  input  logic [NSRC-1:0]          src_used,
  input  logic [NSRC*GPR_AW-1:0]   src_addr,
  input  logic [NSRC*32-1:0]       rf_rdata,
  input  logic [NFWD-1:0]          fwd_valid,
  input  logic [NFWD*GPR_AW-1:0]   fwd_dest,
  input  logic [NFWD*32-1:0]       fwd_data,
  input  logic [NFWD-1:0]          fwd_data_ok,
  input  logic                     retire_valid,
  input  logic [GPR_AW-1:0]        retire_dest,
  input  logic                     flush_all,
  output logic [NSRC*32-1:0]       src_value,
  output logic                     stall,
  output logic [GPR_NUM-1:0]       busy_mask
);
  logic [CW-1:0]        cnt_q [GPR_NUM];
  logic [CW-1:0]        cnt_d [GPR_NUM];
  logic [GPR_NUM-1:0]   inc;
  logic [GPR_NUM-1:0]   dec;
  logic [GPR_NUM-1:0]   busy;
  logic [NSRC-1:0]      port_stall;
  logic                 fire;
  logic                 struct_stall;
  fwd_slot_t [NFWD-1:0] slots;
  always_comb begin
    for (int i = 0; i < NFWD; i++)
      slots[i] = {fwd_dest[i*GPR_AW +: GPR_AW], fwd_data[i*32 +: 32], fwd_data_ok[i], fwd_valid[i]};
  end
  for (genvar p = 0; p < NSRC; p++) begin : g_port
    logic [GPR_AW-1:0] addr;
    assign addr = src_addr[p*GPR_AW +: GPR_AW];
    fwd_select_port #(.NFWD(NFWD)) u_sel (
      .hazard     (src_used[p] && addr != '0 && busy[addr]),
      .addr       (addr),
      .rf_rdata   (rf_rdata[p*32 +: 32]),
      .slots      (slots),
      .value      (src_value[p*32 +: 32]),
      .port_stall (port_stall[p])
    );
  end
  always_comb begin
    struct_stall = issue_we && issue_dest != '0 && cnt_q[issue_dest] == CW'(MAX_INFLIGHT) && !dec[issue_dest];
    stall = issue_valid && (|port_stall || struct_stall);
    issue_ready = !reset && !stall && ex_allow_in;
    fire = issue_valid && issue_ready;
    inc = (fire && issue_we) ? (GPR_NUM'(1) << issue_dest) & ~GPR_NUM'(1) : '0;
    dec = retire_valid ? (GPR_NUM'(1) << retire_dest) & ~GPR_NUM'(1) : '0;
    for (int r = 0; r < GPR_NUM; r++) begin
      busy[r] = cnt_q[r] != '0;
      cnt_d[r] = flush_all ? '0
               : (inc[r] && !dec[r]) ? cnt_q[r] + CW'(1)
               : (dec[r] && !inc[r] && busy[r]) ? cnt_q[r] - CW'(1)
               : cnt_q[r];
    end
    busy_mask = {busy[GPR_NUM-1:1], 1'b0};
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < GPR_NUM; r++) cnt_q[r] <= reset ? '0 : cnt_d[r];
  end
  a_retire_tracked: assert property (@(posedge clk) disable iff (reset)
    (retire_valid && retire_dest != '0 && !flush_all && !inc[retire_dest]) |-> busy[retire_dest]);
endmodule

// File: tb/tb_id_scoreboard_fwd.sv
// tb_id_scoreboard_fwd: table-driven cycle vectors plus divider/reset sequences for id_scoreboard_fwd
module tb_id_scoreboard_fwd;
  localparam logic [31:0] RF0 = 32'h0000_AAAA;
  localparam logic [31:0] RF1 = 32'h0000_BBBB;
  typedef struct {
    string       n;
    logic        iv, ea, we;
    logic [4:0]  dest;
    logic [1:0]  used;
    logic [4:0]  a0, a1;
    logic [2:0]  fv, fok;
    logic [4:0]  fd0, fd1, fd2;
    logic [31:0] d0, d1, d2;
    logic        rv;
    logic [4:0]  rd;
    logic        fl;
    logic        es, er;
    logic [31:0] ev0, ev1, eb;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, ex_allow_in, issue_ready, issue_we;
  logic [4:0]  issue_dest;
  logic [1:0]  src_used;
  logic [9:0]  src_addr;
  logic [63:0] rf_rdata;
  logic [2:0]  fwd_valid, fwd_data_ok;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_data;
  logic        retire_valid;
  logic [4:0]  retire_dest;
  logic        flush_all;
  logic [63:0] src_value;
  logic        stall;
  logic [31:0] busy_mask;
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[$];
  id_scoreboard_fwd #(.NSRC(2), .NFWD(3), .MAX_INFLIGHT(3)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .ex_allow_in(ex_allow_in),
    .issue_ready(issue_ready), .issue_we(issue_we), .issue_dest(issue_dest),
    .src_used(src_used), .src_addr(src_addr), .rf_rdata(rf_rdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
    .retire_valid(retire_valid), .retire_dest(retire_dest), .flush_all(flush_all),
    .src_value(src_value), .stall(stall), .busy_mask(busy_mask)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(string n, logic iv, logic ea, logic we, logic [4:0] dest, logic [1:0] used,
                              logic [4:0] a0, logic [4:0] a1, logic [2:0] fv, logic [2:0] fok,
                              logic [4:0] fd0, logic [4:0] fd1, logic [4:0] fd2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic rv, logic [4:0] rd, logic fl, logic es, logic er,
                              logic [31:0] ev0, logic [31:0] ev1, logic [31:0] eb);
    vec_t v;
    v.n = n; v.iv = iv; v.ea = ea; v.we = we; v.dest = dest; v.used = used; v.a0 = a0; v.a1 = a1;
    v.fv = fv; v.fok = fok; v.fd0 = fd0; v.fd1 = fd1; v.fd2 = fd2; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.rv = rv; v.rd = rd; v.fl = fl; v.es = es; v.er = er; v.ev0 = ev0; v.ev1 = ev1; v.eb = eb;
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic set_idle();
    issue_valid = 1'b0; ex_allow_in = 1'b1; issue_we = 1'b0; issue_dest = '0;
    src_used = '0; src_addr = '0; fwd_valid = '0; fwd_data_ok = '0; fwd_dest = '0; fwd_data = '0;
    retire_valid = 1'b0; retire_dest = '0; flush_all = 1'b0;
  endtask
  task automatic apply(vec_t v);
    issue_valid = v.iv; ex_allow_in = v.ea; issue_we = v.we; issue_dest = v.dest;
    src_used = v.used; src_addr = {v.a1, v.a0};
    fwd_valid = v.fv; fwd_data_ok = v.fok; fwd_dest = {v.fd2, v.fd1, v.fd0}; fwd_data = {v.d2, v.d1, v.d0};
    retire_valid = v.rv; retire_dest = v.rd; flush_all = v.fl;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rf_rdata = {RF1, RF0};
    reset = 1'b1;
    set_idle();
    src_used = 2'b11;
    src_addr = {5'd3, 5'd1};
    #1;
    chk("rst.ready", 32'(issue_ready), 0);
    step();
    step();
    chk("rst.busy", busy_mask, 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.v0", src_value[31:0], RF0);
    chk("rst.v1", src_value[63:32], RF1);
    reset = 1'b0;
    tbl.push_back(mk("idle",       0,1,0,0,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("raw_issue",  1,1,1,5,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("raw_fwd",    1,1,0,0,2'b01,5,0, 3'b001,3'b001,5,0,0, 32'h1234,0,0, 0,0,0, 0,1,32'h1234,RF1,32'h20));
    tbl.push_back(mk("raw_retire", 0,1,0,0,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 1,5,0, 0,1,RF0,RF1,32'h20));
    tbl.push_back(mk("raw_after",  1,1,0,0,2'b01,5,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("lu_issue",   1,1,1,7,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("lu_stall",   1,1,0,0,2'b10,0,7, 3'b001,3'b000,7,0,0, 32'hDEAD,0,0, 0,0,0, 1,0,RF0,RF1,32'h80));
    tbl.push_back(mk("lu_fwd",     1,1,0,0,2'b10,0,7, 3'b010,3'b010,0,7,0, 0,32'hCAFE,0, 0,0,0, 0,1,RF0,32'hCAFE,32'h80));
    tbl.push_back(mk("lu_retire",  0,1,0,0,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 1,7,0, 0,1,RF0,RF1,32'h80));
    tbl.push_back(mk("pr_issue",   1,1,1,3,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("pr_sel",     1,1,0,0,2'b01,3,0, 3'b101,3'b101,3,0,3, 32'hA,0,32'hB, 0,0,0, 0,1,32'hA,RF1,32'h08));
    tbl.push_back(mk("pr_nofall",  1,1,0,0,2'b01,3,0, 3'b101,3'b100,3,0,3, 32'hA,0,32'hB, 0,0,0, 1,0,RF0,RF1,32'h08));
    tbl.push_back(mk("pr_retire",  0,1,0,0,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 1,3,0, 0,1,RF0,RF1,32'h08));
    tbl.push_back(mk("sat1",       1,1,1,4,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("sat2",       1,1,1,4,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h10));
    tbl.push_back(mk("sat3",       1,1,1,4,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h10));
    tbl.push_back(mk("sat_full",   1,1,1,4,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 1,0,RF0,RF1,32'h10));
    tbl.push_back(mk("sat_retire", 1,1,1,4,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 1,4,0, 0,1,RF0,RF1,32'h10));
    tbl.push_back(mk("sat_still",  1,1,1,4,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 1,0,RF0,RF1,32'h10));
    tbl.push_back(mk("r0_read",    1,1,0,0,2'b11,0,0, 3'b001,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h10));
    tbl.push_back(mk("fl_a",       1,1,1,2,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h10));
    tbl.push_back(mk("fl_b",       1,1,1,2,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h14));
    tbl.push_back(mk("fl_flush",   1,1,1,2,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,1, 0,1,RF0,RF1,32'h14));
    tbl.push_back(mk("fl_after",   0,1,0,0,2'b00,0,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("fl_read",    1,1,0,0,2'b11,2,4, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,1,RF0,RF1,32'h0));
    tbl.push_back(mk("ea_low",     1,0,0,0,2'b01,5,0, 3'b000,3'b000,0,0,0, 0,0,0, 0,0,0, 0,0,RF0,RF1,32'h0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      chk({tbl[i].n, ".stall"}, 32'(stall), 32'(tbl[i].es));
      chk({tbl[i].n, ".ready"}, 32'(issue_ready), 32'(tbl[i].er));
      chk({tbl[i].n, ".busy"}, busy_mask, tbl[i].eb);
      if (!tbl[i].es) begin
        chk({tbl[i].n, ".v0"}, src_value[31:0], tbl[i].ev0);
        chk({tbl[i].n, ".v1"}, src_value[63:32], tbl[i].ev1);
      end
      step();
    end
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
    #1;
    chk("div_issue.ready", 32'(issue_ready), 1);
    step();
    issue_we = 1'b0; issue_dest = '0; src_used = 2'b01; src_addr = {5'd0, 5'd9};
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("div_wait%0d.stall", k), 32'(stall), 1);
      step();
    end
    retire_valid = 1'b1; retire_dest = 5'd9;
    #1;
    chk("div_retire.stall", 32'(stall), 1);
    step();
    retire_valid = 1'b0;
    #1;
    chk("div_done.stall", 32'(stall), 0);
    chk("div_done.v0", src_value[31:0], RF0);
    chk("div_done.busy", busy_mask, 0);
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd6;
    step();
    set_idle();
    src_used = 2'b01; src_addr = {5'd0, 5'd6};
    reset = 1'b1;
    #1;
    chk("rst2.ready", 32'(issue_ready), 0);
    chk("rst2.busy_pre", busy_mask, 32'h40);
    step();
    chk("rst2.busy", busy_mask, 0);
    chk("rst2.stall", 32'(stall), 0);
    chk("rst2.v0", src_value[31:0], RF0);
    reset = 1'b0;
    #1;
    chk("rst2.ready_after", 32'(issue_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
